// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } gen_state_t;

    function automatic int unsigned bit_cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Loadable MSB-first shift register; msb is the bit that leaves next.
module seq_gen_shifter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/sequence_generator_fsm.sv
// Serial pattern transmitter: MSB-first frames, repeated with an idle gap.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module sequence_generator_fsm
    import seq_gen_pkg::*;
#(
    parameter int unsigned PATTERN_W  = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic [PATTERN_W-1:0] load_data,
    input  logic [CNT_W-1:0]     repeat_cnt,
    output logic                 load_ready,
    output logic                 data_out,
    output logic                 data_valid,
    output logic                 frame_done,
    output logic [1:0]           state
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned FRAME_LEN = PATTERN_W + PAR_BITS;
    localparam int unsigned BCW       = bit_cnt_width(PATTERN_W);
    localparam int unsigned GW        = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    localparam logic [BCW-1:0] LAST_IDX    = BCW'(FRAME_LEN - 1);
    localparam logic [BCW-1:0] PRELAST_IDX = BCW'(FRAME_LEN - 2);
    localparam logic [GW-1:0]  GAP_LAST    = GW'(GAP_CYCLES);

    gen_state_t           st;
    logic [PATTERN_W-1:0] pattern;
    logic [CNT_W-1:0]     frames_left;
    logic [BCW-1:0]       bit_cnt;
    logic [GW-1:0]        gap_cnt;

    logic                 accept;
    logic                 frame_end;
    logic                 more_frames;
    logic                 reload;
    logic                 sh_load;
    logic                 sh_shift;
    logic                 sh_msb;
    logic                 next_bit;
    logic [PATTERN_W-1:0] sh_src;

    always_comb begin
        accept      = load_valid && (st == IDLE);
        frame_end   = (st == SHIFT) && (bit_cnt == LAST_IDX);
        more_frames = frames_left > CNT_W'(1);
        reload      = (frame_end && more_frames && (GAP_CYCLES == 0))
                   || ((st == GAP) && (gap_cnt == GAP_LAST));
        sh_load     = accept || reload;
        sh_shift    = (st == SHIFT) && !frame_end;
        sh_src      = accept ? load_data : pattern;
`ifdef SEQ_GEN_PARITY_EN
        next_bit    = (bit_cnt == BCW'(PATTERN_W - 1)) ? ^pattern : sh_msb;
`else
        next_bit    = sh_msb;
`endif
    end

    // The MSB goes straight to data_out on the load edge, so the shifter
    // is loaded one position ahead and always holds the following bit.
    seq_gen_shifter #(
        .W (PATTERN_W)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   ({sh_src[PATTERN_W-2:0], 1'b0}),
        .msb   (sh_msb)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            pattern     <= '0;
            frames_left <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (accept) begin
                        st          <= SHIFT;
                        pattern     <= load_data;
                        frames_left <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                        bit_cnt     <= '0;
                        data_out    <= sh_src[PATTERN_W-1];
                        data_valid  <= 1'b1;
                    end else begin
                        data_out   <= 1'b0;
                        data_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!frame_end) begin
                        bit_cnt    <= bit_cnt + BCW'(1);
                        data_out   <= next_bit;
                        data_valid <= 1'b1;
                        frame_done <= (bit_cnt == PRELAST_IDX) && (frames_left == CNT_W'(1));
                    end else if (more_frames) begin
                        frames_left <= frames_left - CNT_W'(1);
                        frame_done  <= 1'b0;
                        if (reload) begin
                            bit_cnt    <= '0;
                            data_out   <= sh_src[PATTERN_W-1];
                            data_valid <= 1'b1;
                        end else begin
                            st         <= GAP;
                            gap_cnt    <= GW'(1);
                            data_out   <= 1'b0;
                            data_valid <= 1'b0;
                        end
                    end else begin
                        st         <= IDLE;
                        data_out   <= 1'b0;
                        data_valid <= 1'b0;
                        frame_done <= 1'b0;
                    end
                end
                GAP: begin
                    frame_done <= 1'b0;
                    if (reload) begin
                        st         <= SHIFT;
                        bit_cnt    <= '0;
                        data_out   <= sh_src[PATTERN_W-1];
                        data_valid <= 1'b1;
                    end else begin
                        gap_cnt    <= gap_cnt + GW'(1);
                        data_out   <= 1'b0;
                        data_valid <= 1'b0;
                    end
                end
                default: begin
                    st         <= IDLE;
                    data_out   <= 1'b0;
                    data_valid <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = (st == IDLE);
    assign state      = st;

endmodule

// File: tb/tb_sequence_generator_fsm.sv
// Scoreboard bench for sequence_generator_fsm: GAP=2 and GAP=0 instances share stimulus.
module tb_sequence_generator_fsm;

`ifdef SEQ_GEN_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam int GAP = 2;

    typedef struct {
        logic b;
        logic d;
        int   c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic [3:0] repeat_cnt;

    logic       rdy1, do1, dv1, fd1;
    logic [1:0] st1;
    logic       rdy0, do0, dv0, fd0;
    logic [1:0] st0;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    exp_t q1[$];
    exp_t q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sequence_generator_fsm #(
        .PATTERN_W  (8),
        .CNT_W      (4),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .repeat_cnt (repeat_cnt),
        .load_ready (rdy1),
        .data_out   (do1),
        .data_valid (dv1),
        .frame_done (fd1),
        .state      (st1)
    );

    sequence_generator_fsm #(
        .PATTERN_W  (8),
        .CNT_W      (4),
        .GAP_CYCLES (0)
    ) dut_nogap (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .repeat_cnt (repeat_cnt),
        .load_ready (rdy0),
        .data_out   (do0),
        .data_valid (dv0),
        .frame_done (fd0),
        .state      (st0)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int which, input logic dv, input logic dout, input logic fd);
        exp_t e;
        int   qs;
        qs = (which == 0) ? q0.size() : q1.size();
        if (dv) begin
            if (qs == 0) begin
                check($sformatf("unexpected_valid_g%0d", which), 1, 0);
            end else begin
                if (which == 0) e = q0.pop_front();
                else            e = q1.pop_front();
                check($sformatf("bit_g%0d", which), dout, e.b);
                check($sformatf("done_g%0d", which), fd, e.d);
                check($sformatf("cycle_g%0d", which), cyc, e.c);
            end
        end else begin
            check($sformatf("idle_out_g%0d", which), dout, 0);
            check($sformatf("idle_done_g%0d", which), fd, 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(1, dv1, do1, fd1);
            mon(0, dv0, do0, fd0);
        end
    end

    task automatic wait_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // frame holds the hand-computed frame bits MSB-first: {pattern, parity}.
    task automatic do_job(input logic [7:0] data, input logic [3:0] rep,
                          input logic [8:0] frame, input int nframes,
                          input int keep, output int a);
        int   n;
        int   idx;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy1 && n < 100);
        if (!rdy1) check("ready_timeout", 0, 1);
        load_valid = 1'b1;
        load_data  = data;
        repeat_cnt = rep;
        @(posedge clk);
        #1;
        a = cyc;
        load_valid = 1'b0;
        for (int f = 0; f < nframes; f++) begin
            for (int b = 0; b < FL; b++) begin
                idx = f * FL + b;
                if (keep < 0 || idx < keep) begin
                    e.b = frame[8 - b];
                    e.d = (f == nframes - 1) && (b == FL - 1);
                    e.c = a + f * (FL + GAP) + b;
                    q1.push_back(e);
                    e.c = a + f * FL + b;
                    q0.push_back(e);
                end
            end
        end
    endtask

    initial begin
        int a;
        int last;
        int a2;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int last;
        int a2;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat_cnt = '0;
        #1;
        check("rst_state", st1, 0);
        check("rst_valid", dv1, 0);
        check("rst_done", fd1, 0);
        check("rst_ready", rdy1, 1);
        check("rst_dout", do1, 0);
        reset = 1'b1;
        #1;
        check("post_rst_state", st1, 0);
        check("post_rst_ready", rdy1, 1);
        mon_en = 1'b1;

        // single frame: 0,1,0,1,0,1,1,0 (+ parity 0)
        do_job(8'b0101_0110, 4'd1, {8'b0101_0110, 1'b0}, 1, -1, a);
        last = a + FL - 1;
        wait_cycle(last + 1);
        check("t2_idle_state", st1, 0);
        check("t2_idle_ready", rdy1, 1);

        // two frames with gap; GAP=0 instance runs them contiguously
        do_job(8'hC3, 4'd2, {8'hC3, 1'b0}, 2, -1, a);
        wait_cycle(a + FL);
        check("t3_gap_state", st1, 2);
        check("t3_gap_ready", rdy1, 0);
        check("t3_nogap_state", st0, 1);
        last = a + 2 * FL + GAP - 1;
        wait_cycle(last);

        // back-to-back: accepted in the first IDLE cycle after frame_done
        do_job(8'h3C, 4'd1, {8'h3C, 1'b0}, 1, -1, a2);
        check("b2b_start", a2, last + 2);

        // repeat_cnt=0 acts as 1; load during SHIFT is ignored
        do_job(8'h96, 4'd0, {8'h96, 1'b0}, 1, -1, a);
        wait_cycle(a + 2);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        repeat_cnt = 4'd5;
        check("busy_ready", rdy1, 0);
        @(negedge clk);
        load_valid = 1'b0;
        wait_cycle(a + FL + 3);
        check("t4_no_restart", st1, 0);

        // reset during bit 4 of a repeat-3 job
        do_job(8'hF0, 4'd3, {8'hF0, 1'b0}, 3, 4, a);
        wait_cycle(a + 3);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t5_valid", dv1, 0);
        check("t5_dout", do1, 0);
        check("t5_done", fd1, 0);
        check("t5_state", st1, 0);
        check("t5_valid_g0", dv0, 0);
        check("t5_dout_g0", do0, 0);
        check("t5_left", q1.size(), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        do_job(8'hFF, 4'd1, {8'hFF, 1'b0}, 1, -1, a);

        // parity cases: A5 -> parity 0, 07 -> parity 1
        do_job(8'hA5, 4'd1, {8'hA5, 1'b0}, 1, -1, a);
        do_job(8'h07, 4'd1, {8'h07, 1'b1}, 1, -1, a);
        wait_cycle(a + FL + 5);
        check("drain_g2", q1.size(), 0);
        check("drain_g0", q0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
